uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among N_REQ byte producers, such as a debug console, status reporter and error logger. It round-robin arbitrates between requesters and hands the winning byte to the transmitter with a one-cycle start pulse. It then tracks the transmitter's busy line until the frame completes. It sits between the requester logic and the uart_tx serializer, which must expose a start/busy interface.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 1024, max cycles to wait for tx_busy to rise after tx_start
GAP_CYCLES, 16, idle cycles inserted between frames (only with the optional feature)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester byte-pending flag; held until matching req_ready
req_data  in  8*N_REQ  byte of requester k at [8k+7:8k]
req_ready  out  N_REQ  one-hot one-cycle accept pulse
tx_data  out  8  byte to the transmitter; stable from tx_start until tx_busy falls
tx_start  out  1  one-cycle start pulse to the transmitter
tx_busy  in  1  transmitter busy; high from at most TIMEOUT cycles after tx_start until the stop bit ends
grant_id  out  clog2(N_REQ)  index of the current/last granted requester
arb_busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse on tx_busy falling edge
timeout_err  out  1  one-cycle pulse when tx_busy fails to rise within TIMEOUT

Behaviour:
- Reset (synchronous, active-high): state=IDLE; req_ready=0, tx_start=0, tx_data=8'h00, grant_id=0, arb_busy=0, frame_done=0, timeout_err=0, last_grant=N_REQ-1, counters=0. Reset mid-frame aborts immediately; no pulse is emitted.
- All outputs are registered.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If any req_valid is high in cycle n, select the first set bit scanning from (last_grant+1) mod N_REQ upward with wrap.
  - In cycle n+1: state=START, req_ready[g]=1, tx_start=1, tx_data=req_data[g], grant_id=g, last_grant=g.
  - If req_valid==0, stay in IDLE.
- START: lasts one cycle, then WAIT_BUSY. req_ready and tx_start are low again from cycle n+2.
- WAIT_BUSY:
  - Cycle counter starts at 0.
  - tx_busy=1 -> WAIT_DONE.
  - Counter reaching TIMEOUT-1 with tx_busy still 0 -> pulse timeout_err, go to IDLE. The byte is dropped; it was already accepted.
- WAIT_DONE: tx_busy=0 -> pulse frame_done, go to GAP (feature on) or IDLE (feature off).
- GAP: count GAP_CYCLES cycles, then IDLE.
- Throughput: back-to-back requests are granted no earlier than the cycle after IDLE is re-entered.
- Latency: valid seen in cycle n -> tx_start in cycle n+1.
- req_valid changes outside IDLE are ignored. A requester that deasserts valid before its ready is never granted.
- tx_busy already high in START is tolerated: WAIT_BUSY exits on its first cycle.
- Width rules: counters sized clog2(max(TIMEOUT,GAP_CYCLES))+1; round-robin index wraps modulo N_REQ, including for non-power-of-two N_REQ.

Optional Feature:
Macro: UART_TX_ARB_GAP_EN.
- Defined: WAIT_DONE -> GAP, and GAP_CYCLES idle-line cycles separate consecutive frames.
- Undefined: the GAP state and its counter are not compiled; WAIT_DONE -> IDLE directly, and GAP_CYCLES is ignored.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding constants (IDLE=0, START=1, WAIT_BUSY=2, WAIT_DONE=3, GAP=4; 3-bit)
  - the clog2 function
  - the byte-width constant UART_DW=8
- One sub-module, uart_rr_arbiter: combinational round-robin pick with inputs req and last_grant, outputs grant_onehot, grant_idx and any_req.
- FSM, counters and registers stay in uart_tx_arbiter.

Test Plan:
- Single request: req_valid=4'b0100, data 8'h41 -> next cycle req_ready=4'b0100, tx_start=1, tx_data=8'h41, grant_id=2. Model raises tx_busy after 3 cycles and drops it after 100 -> frame_done pulses once, arb_busy=0 afterwards.
- Fairness: all four valid continuously, each re-asserted after ready -> grant order 0,1,2,3,0,1 with no requester granted twice in a row.
- Timeout: TIMEOUT=8, tx_busy held 0 -> timeout_err pulses in the 8th WAIT_BUSY cycle, FSM returns to IDLE, and the next request is served normally.
- Reset mid-frame: rst=1 during WAIT_DONE -> next cycle all outputs at reset values, no frame_done. After release, req_valid=4'b0001 is granted (grant_id=0).
- Gap (UART_TX_ARB_GAP_EN, GAP_CYCLES=16): two queued requests -> tx_start edges are separated by busy duration +16 cycles +3. Without the macro, the separation is busy duration +3.
- tx_data stability: requester changes req_data after ready -> tx_data is unchanged until frame_done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
// Contents: byte width, FSM state encoding and a constant-foldable clog2.
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } arb_state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the arbiter and the uart_tx
// serializer.
//   req_valid/req_data/req_ready : per-requester byte handshake
//   tx_data/tx_start/tx_busy     : transmitter start/busy interface
//   grant_id/arb_busy            : arbitration status
//   frame_done/timeout_err       : one-cycle completion / failure pulses
// Modport master is the arbiter; modport slave is the surrounding logic.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) ();
  localparam int GW = clog2(N_REQ);

  logic [N_REQ-1:0]         req_valid;
  logic [UART_DW*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]         req_ready;
  logic [UART_DW-1:0]       tx_data;
  logic                     tx_start;
  logic                     tx_busy;
  logic [GW-1:0]            grant_id;
  logic                     arb_busy;
  logic                     frame_done;
  logic                     timeout_err;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_data, tx_start, grant_id, arb_busy, frame_done, timeout_err
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_data, tx_start, grant_id, arb_busy, frame_done, timeout_err
  );
endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick.
//   req          : pending requests
//   last_grant   : index granted last time; scanning starts just above it
//   grant_onehot : one-hot winner (zero when nothing pending)
//   grant_idx    : winner index
//   any_req      : at least one request pending
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int GW = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [GW-1:0]    grant_idx,
  output logic             any_req
);

  // Each requester gets a rotated distance from last_grant+1; the smallest
  // distance among pending requesters wins. Works for any N_REQ, not only
  // powers of two.
  always_comb begin
    int off;
    int best;
    off          = 0;
    best         = N_REQ;
    grant_onehot = '0;
    grant_idx    = '0;
    any_req      = |req;
    for (int j = 0; j < N_REQ; j++) begin
      off = j - int'(last_grant) - 1;
      if (off < 0) off = off + N_REQ;
      if (off < 0) off = off + N_REQ;
      if (req[j] && (off < best)) begin
        best            = off;
        grant_onehot    = '0;
        grant_onehot[j] = 1'b1;
        grant_idx       = GW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte producers. Round-robin picks a
// requester, issues a one-cycle tx_start with the byte, then follows tx_busy
// until the frame ends (frame_done) or busy never rises (timeout_err).
// Ports: clk, rst (synchronous, active-high), bus (uart_tx_arbiter_if.master).
// Optional macro UART_TX_ARB_GAP_EN: inserts GAP_CYCLES idle cycles after
// each completed frame; without it WAIT_DONE returns straight to IDLE.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int TIMEOUT    = 1024,
  parameter int GAP_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  localparam int GW = clog2(N_REQ);
  localparam int CW = clog2((TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
`ifdef UART_TX_ARB_GAP_EN
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
`endif

  arb_state_t         state;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_start;
  logic [UART_DW-1:0] tx_data;
  logic [GW-1:0]      grant_id;
  logic [GW-1:0]      last_grant;
  logic               arb_busy;
  logic               frame_done;
  logic               timeout_err;
  logic [CW-1:0]      wait_cnt;
`ifdef UART_TX_ARB_GAP_EN
  logic [CW-1:0]      gap_cnt;
`endif

  logic [N_REQ-1:0]   pick_onehot;
  logic [GW-1:0]      pick_idx;
  logic               pick_any;
  logic [UART_DW-1:0] pick_data;

  uart_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req          (bus.req_valid),
    .last_grant   (last_grant),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .any_req      (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick_onehot[j]) pick_data = bus.req_data[j*UART_DW +: UART_DW];
    end
  end

  // Pulses default low each cycle; tx_data and grant_id hold until the next
  // grant so the serializer sees a stable byte for the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      last_grant  <= GW'(N_REQ - 1);
      arb_busy    <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
`ifdef UART_TX_ARB_GAP_EN
      gap_cnt     <= '0;
`endif
    end else begin
      req_ready   <= '0;
      tx_start    <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state      <= ST_START;
            req_ready  <= pick_onehot;
            tx_start   <= 1'b1;
            tx_data    <= pick_data;
            grant_id   <= pick_idx;
            last_grant <= pick_idx;
            arb_busy   <= 1'b1;
          end
        end
        ST_START: begin
          state    <= ST_WAIT_BUSY;
          wait_cnt <= '0;
        end
        // Busy is tested before the counter, so busy arriving in the final
        // allowed cycle still counts as a successful start.
        ST_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (wait_cnt == TO_LAST) begin
            state       <= ST_IDLE;
            arb_busy    <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            frame_done <= 1'b1;
`ifdef UART_TX_ARB_GAP_EN
            state      <= ST_GAP;
            gap_cnt    <= '0;
`else
            state      <= ST_IDLE;
            arb_busy   <= 1'b0;
`endif
          end
        end
`ifdef UART_TX_ARB_GAP_EN
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= ST_IDLE;
            arb_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif
        default: begin
          state    <= ST_IDLE;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.tx_start    = tx_start;
  assign bus.tx_data     = tx_data;
  assign bus.grant_id    = grant_id;
  assign bus.arb_busy    = arb_busy;
  assign bus.frame_done  = frame_done;
  assign bus.timeout_err = timeout_err;

endmodule
